// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the IO bus arbiter: FSM state encoding and the
// read data returned when a slave transaction is aborted by the timeout.
package io_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Master index encoded by a one-hot two-bit grant vector.
  function automatic logic grant_id(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester always wins; when both
// request, the one that was not granted last wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO bus between the core (m0) and the debug
// loader (m1). Optional slave-wait timeout is enabled by IO_ARB_TIMEOUT_EN.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_wr,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_wr,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          s_valid,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_wr,
  input  logic          s_ready,
  input  logic [DW-1:0] s_rdata,
  output logic          to_err,
  output logic [1:0]    dbg_state
);

  // Handshake: a master request is taken in the cycle where mN_valid and
  // mN_ready are both high. ready is only ever raised in IDLE, for the granted
  // master. Completion is signalled by a one-cycle mN_rvalid pulse; the slave
  // side completes a transaction in any BUSY cycle where s_ready is high.

  arb_state_e    state_q, state_d;
  logic          last_gnt_q;
  logic          id_q;
  logic [AW-1:0] s_addr_q;
  logic [DW-1:0] s_wdata_q;
  logic          s_wr_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    gnt;
  logic          accept;
  logic          timeout_hit;

  rr_arb2 u_rr_arb2 (
    .valid    ({m1_valid, m0_valid}),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  assign accept = (state_q == IDLE) && (gnt != 2'b00);

  assign m0_ready  = (state_q == IDLE) && gnt[0];
  assign m1_ready  = (state_q == IDLE) && gnt[1];
  assign m0_rvalid = (state_q == RESP) && !id_q;
  assign m1_rvalid = (state_q == RESP) && id_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign s_valid   = (state_q == BUSY);
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wr      = s_wr_q;
  assign dbg_state = state_q;

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             to_err_q;

  // The cycle that would push the count to TIMEOUT aborts instead; a
  // concurrent s_ready still completes the transaction normally.
  assign timeout_hit = (state_q == BUSY) && !s_ready && (wait_cnt_q == TO_LAST);
  assign to_err      = to_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      to_err_q   <= 1'b0;
    end else begin
      to_err_q <= timeout_hit;
      if (accept) begin
        wait_cnt_q <= '0;
      end else if ((state_q == BUSY) && !s_ready && !timeout_hit) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (s_ready || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q      <= grant_id(gnt);
        s_addr_q  <= gnt[1] ? m1_addr  : m0_addr;
        s_wdata_q <= gnt[1] ? m1_wdata : m0_wdata;
        s_wr_q    <= gnt[1] ? m1_wr    : m0_wr;
      end
      // Writes return zero so a master never sees stale slave data.
      if ((state_q == BUSY) && s_ready) begin
        rdata_q <= s_wr_q ? '0 : s_rdata;
      end else if (timeout_hit) begin
        rdata_q <= DW'(ERR_RDATA);
      end
      if (state_q == RESP) begin
        last_gnt_q <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter; completions are checked against a
// scoreboard of expected {to_err, id, rdata} entries.
module tb_io_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = DW + 2;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_valid = 1'b0, m0_ready, m0_wr = 1'b0, m0_rvalid;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m0_rdata;
  logic          m1_valid = 1'b0, m1_ready, m1_wr = 1'b0, m1_rvalid;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0, m1_rdata;
  logic          s_valid, s_wr, s_ready = 1'b0, to_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata = '0;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  logic [EW-1:0] exp_q[$];

  io_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wr(m0_wr), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wr(m1_wr), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wr(s_wr),
    .s_ready(s_ready), .s_rdata(s_rdata), .to_err(to_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver helpers: inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic err, input logic id, input logic [DW-1:0] data);
    exp_q.push_back({err, id, data});
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      rv_count++;
      check("rvalid_onehot", 64'(m0_rvalid && m1_rvalid), 64'd0);
      check("rvalid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("completion", 64'({to_err, m1_rvalid, (m1_rvalid ? m1_rdata : m0_rdata)}),
              64'(exp_q.pop_front()));
      end
    end else if (to_err) begin
      check("to_err_without_rvalid", 64'(to_err), 64'd0);
    end
  end

  initial begin
    int rv_snap;
    // Reset state
    step();
    step();
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_s_addr", 64'(s_addr), 64'd0);
    check("rst_s_wr", 64'(s_wr), 64'd0);
    check("rst_to_err", 64'(to_err), 64'd0);
    step();
    reset = 1'b0;

    // 1: single m0 read, minimum latency
    m0_valid = 1'b1; m0_addr = 32'h0040_0004; m0_wr = 1'b0;
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    push_exp(1'b0, 1'b0, 32'h1234_5678);
    @(negedge clk);
    check("t1_m0_ready_c0", 64'(m0_ready), 64'd1);
    check("t1_m1_ready_c0", 64'(m1_ready), 64'd0);
    check("t1_s_valid_c0", 64'(s_valid), 64'd0);
    step();
    m0_valid = 1'b0;
    @(negedge clk);
    check("t1_s_valid_c1", 64'(s_valid), 64'd1);
    check("t1_s_addr_c1", 64'(s_addr), 64'h0040_0004);
    check("t1_m0_ready_c1", 64'(m0_ready), 64'd0);
    step();
    @(negedge clk);
    check("t1_m0_rvalid_c2", 64'(m0_rvalid), 64'd1);
    step();
    s_ready = 1'b0;

    // 2: both masters held valid after reset alternate m0,m1,m0,m1
    reset = 1'b1;
    step();
    reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0040_0020; m0_wr = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h0040_0024; m1_wr = 1'b0;
    s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic want1;
      want1 = k[0];
      s_rdata = 32'hC0DE_0000 + 32'(k);
      push_exp(1'b0, want1, 32'hC0DE_0000 + 32'(k));
      @(negedge clk);
      check("t2_m0_ready", 64'(m0_ready), 64'(!want1));
      check("t2_m1_ready", 64'(m1_ready), 64'(want1));
      step();
      @(negedge clk);
      check("t2_s_addr", 64'(s_addr), want1 ? 64'h0040_0024 : 64'h0040_0020);
      step();
      @(negedge clk);
      check("t2_rvalid", 64'(want1 ? m1_rvalid : m0_rvalid), 64'd1);
      step();
      if (k == 3) begin
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
      end
    end
    step();

    // 3: m1 write with a 5-cycle slave wait
    m1_valid = 1'b1; m1_addr = 32'h0040_0008; m1_wdata = 32'h41; m1_wr = 1'b1;
    s_ready = 1'b0; s_rdata = 32'hFFFF_FFFF;
    push_exp(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    check("t3_m1_ready", 64'(m1_ready), 64'd1);
    step();
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_s_valid", 64'(s_valid), 64'd1);
      check("t3_s_addr", 64'(s_addr), 64'h0040_0008);
      check("t3_s_wdata", 64'(s_wdata), 64'h41);
      check("t3_s_wr", 64'(s_wr), 64'd1);
      step();
      if (i == 3) s_ready = 1'b1;
    end
    s_ready = 1'b0;
    @(negedge clk);
    check("t3_m1_rvalid", 64'(m1_rvalid), 64'd1);
    check("t3_m1_rdata", 64'(m1_rdata), 64'd0);
    step();

    // 6: s_ready in IDLE with no request is ignored
    rv_snap = rv_count;
    s_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_state", 64'(dbg_state), 64'd0);
      check("t6_s_valid", 64'(s_valid), 64'd0);
      step();
    end
    s_ready = 1'b0;
    check("t6_no_rvalid", 64'(rv_count), 64'(rv_snap));

    // 4: reset during BUSY drops the transaction; m0 wins afterwards
    m0_valid = 1'b1; m0_addr = 32'h0040_0010; m0_wr = 1'b0;
    s_ready = 1'b1; s_rdata = 32'hA5A5_0001;
    push_exp(1'b0, 1'b0, 32'hA5A5_0001);
    @(negedge clk);
    check("t4_pre_m0_ready", 64'(m0_ready), 64'd1);
    step();
    m0_valid = 1'b0;
    step();
    step();
    s_ready = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h0040_000C; m1_wr = 1'b0;
    @(negedge clk);
    check("t4_m1_ready", 64'(m1_ready), 64'd1);
    step();
    m1_valid = 1'b0;
    rv_snap = rv_count;
    @(negedge clk);
    check("t4_busy", 64'(s_valid), 64'd1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("t4_s_valid_after_rst", 64'(s_valid), 64'd0);
    check("t4_state_after_rst", 64'(dbg_state), 64'd0);
    step();
    reset = 1'b0;
    check("t4_no_rvalid", 64'(rv_count), 64'(rv_snap));
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'hB0B0_0002;
    push_exp(1'b0, 1'b0, 32'hB0B0_0002);
    @(negedge clk);
    check("t4_dual_m0_ready", 64'(m0_ready), 64'd1);
    check("t4_dual_m1_ready", 64'(m1_ready), 64'd0);
    step();
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();
    @(negedge clk);
    check("t4_m0_rvalid", 64'(m0_rvalid), 64'd1);
    step();
    s_ready = 1'b0;

    // 5: slave never answers
    reset = 1'b1;
    step();
    reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0040_0014; m0_wr = 1'b0;
    s_ready = 1'b0; s_rdata = 32'h1111_1111;
`ifdef IO_ARB_TIMEOUT_EN
    push_exp(1'b1, 1'b0, ERR_WORD);
`endif
    @(negedge clk);
    check("t5_m0_ready", 64'(m0_ready), 64'd1);
    step();
    m0_valid = 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_busy", 64'(s_valid), 64'd1);
      check("t5_to_err_busy", 64'(to_err), 64'd0);
      step();
    end
    @(negedge clk);
    check("t5_m0_rvalid", 64'(m0_rvalid), 64'd1);
    check("t5_to_err", 64'(to_err), 64'd1);
    check("t5_rdata", 64'(m0_rdata), 64'(ERR_WORD));
    step();
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t5_busy", 64'(s_valid), 64'd1);
      check("t5_to_err", 64'(to_err), 64'd0);
      step();
    end
    @(negedge clk);
    check("t5_still_busy", 64'(dbg_state), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    // Final report
    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
